// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and helpers for the systolic operand skew feeder.
package systolic_skew_feeder_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_DEF      = 4;
  localparam int K_W_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Last product reaches PE(N-1,N-1) 2N-1 edges after the final acceptance.
  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int flush_cnt_w(input int n);
    return $clog2(2 * n);
  endfunction

  localparam int FLUSH_CYCLES = flush_cycles(N_DEF);
  localparam int FLUSH_CNT_W  = flush_cnt_w(N_DEF);

  function automatic logic [DATA_W_DEF-1:0] lane(input logic [N_DEF*DATA_W_DEF-1:0] vec,
                                                 input int i);
    return vec[i*DATA_W_DEF +: DATA_W_DEF];
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage register chain; shifts every cycle, cleared by synchronous reset.
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for an N x N systolic MAC array: clears the PEs, skews lane i
// by i cycles, pads stalls and the tail with zeros, and pulses done when sums are final.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N      = N_DEF,
  parameter int K_W    = K_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [K_W-1:0]      k_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_a,
  input  logic [N*DATA_W-1:0] in_b,
  output logic [N*DATA_W-1:0] out_a,
  output logic [N*DATA_W-1:0] out_b,
  output logic                pe_clear,
  output logic                busy,
  output logic                done
);

  localparam int FLUSH_LEN = flush_cycles(N);
  localparam int FC_W      = flush_cnt_w(N);

  state_e          state_q;
  logic [K_W-1:0]  k_len_q;
  logic [K_W-1:0]  vec_cnt_q;
  logic [FC_W-1:0] flush_cnt_q;
  logic            in_ready_q;
  logic            pe_clear_q;
  logic            busy_q;
  logic            done_q;
  logic            accept;

  // in_ready_q is high exactly while in STREAM, so it doubles as the handshake gate.
  assign accept = in_valid & in_ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      vec_cnt_q   <= '0;
      flush_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      pe_clear_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pe_clear_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            k_len_q    <= k_len;
            vec_cnt_q  <= '0;
            state_q    <= ST_CLEAR;
            pe_clear_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (k_len_q != '0) begin
            state_q    <= ST_STREAM;
            in_ready_q <= 1'b1;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            vec_cnt_q <= vec_cnt_q + K_W'(1);
            if (vec_cnt_q == k_len_q - K_W'(1)) begin
              state_q     <= ST_FLUSH;
              flush_cnt_q <= '0;
              in_ready_q  <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == FC_W'(FLUSH_LEN - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + FC_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign pe_clear = pe_clear_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Anything other than an accepted vector enters the chains as zero.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_d;

    assign a_d = accept ? in_a[i*DATA_W +: DATA_W] : '0;
    assign b_d = accept ? in_b[i*DATA_W +: DATA_W] : '0;

    skew_delay_line #(.DEPTH(i + 1), .DATA_W(DATA_W)) u_dly_a (
      .clk   (clk),
      .reset (reset),
      .d_i   (a_d),
      .q_o   (out_a[i*DATA_W +: DATA_W])
    );

    skew_delay_line #(.DEPTH(i + 1), .DATA_W(DATA_W)) u_dly_b (
      .clk   (clk),
      .reset (reset),
      .d_i   (b_d),
      .q_o   (out_b[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: planned jobs replayed cycle by cycle against a
// timeline model, plus a 4x4 PE array model checked against the golden A*B product.
module tb_systolic_skew_feeder;
  import systolic_skew_feeder_pkg::*;

  localparam int DW   = DATA_W_DEF;
  localparam int NL   = N_DEF;
  localparam int KW   = K_W_DEF;
  localparam int VW   = NL * DW;
  localparam int OW   = 2 * VW + 4;
  localparam int MAXC = 128;
  localparam int MAXV = 16;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready, pe_clear, busy, done;
  logic [KW-1:0] k_len;
  logic [VW-1:0] in_a, in_b, out_a, out_b;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  systolic_skew_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_a    (out_a),
    .out_b    (out_b),
    .pe_clear (pe_clear),
    .busy     (busy),
    .done     (done)
  );

  logic [VW-1:0] job_a [MAXV];
  logic [VW-1:0] job_b [MAXV];
  int            job_gap [MAXV];

  logic          st_valid [MAXC];
  logic          st_start [MAXC];
  logic [KW-1:0] st_k     [MAXC];
  logic [VW-1:0] st_a     [MAXC];
  logic [VW-1:0] st_b     [MAXC];
  logic [VW-1:0] slot_a   [MAXC];
  logic [VW-1:0] slot_b   [MAXC];
  logic [OW-1:0] exp_o    [MAXC];
  logic [OW-1:0] obs_o    [MAXC];
  logic [VW-1:0] obs_a    [MAXC];
  logic [VW-1:0] obs_b    [MAXC];
  int            n_cyc;
  int            done_cyc;

  // Cycle 0 = IDLE cycle carrying start. Cycle 1 = CLEAR. Stream opens at cycle 2;
  // vector v is offered exactly on its acceptance cycle, zero bubbles in between.
  task automatic plan_job(input int k, input bit noise, input int tail);
    int acc [MAXV];
    int last;
    logic [VW-1:0] ea, eb;
    logic rdy, clr, bsy, dn;
    last = 1;
    for (int v = 0; v < k; v++) begin
      acc[v] = ((v == 0) ? 2 : acc[v-1] + 1) + job_gap[v];
      last   = acc[v];
    end
    done_cyc = (k == 0) ? 2 : last + 2 * NL;
    n_cyc    = done_cyc + tail + 1;
    for (int c = 0; c < n_cyc; c++) begin
      slot_a[c]   = '0;
      slot_b[c]   = '0;
      st_start[c] = (c == 0) || (noise && c >= 1 && c < done_cyc);
      st_k[c]     = (c == 0) ? KW'(k) : KW'($urandom);
      st_a[c]     = VW'($urandom);
      st_b[c]     = VW'($urandom);
      st_valid[c] = !(k > 0 && c >= 2 && c <= last);
    end
    for (int v = 0; v < k; v++) begin
      st_valid[acc[v]] = 1'b1;
      st_a[acc[v]]     = job_a[v];
      st_b[acc[v]]     = job_b[v];
      slot_a[acc[v]]   = job_a[v];
      slot_b[acc[v]]   = job_b[v];
    end
    for (int c = 0; c < n_cyc; c++) begin
      ea = '0;
      eb = '0;
      for (int i = 0; i < NL; i++) begin
        if (c - i - 1 >= 0) begin
          ea[i*DW +: DW] = lane(slot_a[c-i-1], i);
          eb[i*DW +: DW] = lane(slot_b[c-i-1], i);
        end
      end
      rdy = (k > 0) && c >= 2 && c <= last;
      clr = (c == 1);
      bsy = (c >= 1) && (c <= done_cyc);
      dn  = (c == done_cyc);
      exp_o[c] = {ea, eb, rdy, clr, bsy, dn};
    end
  endtask

  task automatic run_planned();
    for (int c = 0; c < n_cyc; c++) begin
      @(posedge clk);
      #1;
      start    = st_start[c];
      k_len    = st_k[c];
      in_valid = st_valid[c];
      in_a     = st_a[c];
      in_b     = st_b[c];
      @(negedge clk);
      obs_a[c] = out_a;
      obs_b[c] = out_b;
      obs_o[c] = {out_a, out_b, in_ready, pe_clear, busy, done};
    end
  endtask

  // PE(i,j) sees row-i A delayed j cycles and column-j B delayed i cycles;
  // only products in cycles after the clear and before done count.
  function automatic int pe_sum(input int i, input int j);
    int s = 0;
    for (int c = 2; c < done_cyc; c++)
      if (c - j >= 0 && c - i >= 0)
        s += int'(lane(obs_a[c-j], i)) * int'(lane(obs_b[c-i], j));
    return s;
  endfunction

  function automatic int golden(input int i, input int j, input int k);
    int s = 0;
    for (int v = 0; v < k; v++) s += int'(lane(job_a[v], i)) * int'(lane(job_b[v], j));
    return s;
  endfunction

  task automatic test_reset();
    logic [OW-1:0] o;
    @(negedge clk);
    o = {out_a, out_b, in_ready, pe_clear, busy, done};
    tests++;
    if (o !== '0) begin failed++; $display("FAIL reset_state got=%h exp=0", o); end
    // reset and start together: reset wins
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; k_len = 8'd5; in_valid = 1'b1;
    in_a = VW'($urandom); in_b = VW'($urandom);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL reset_vs_start busy got=%b exp=0", busy); end
    // abort mid-STREAM after 3 accepts of an 8-vector job
    @(posedge clk); #1;
    start = 1'b1; k_len = 8'd8; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = VW'($urandom) | 32'h0101_0101; in_b = VW'($urandom) | 32'h0101_0101;
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL abort_pre_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      o = {out_a, out_b, in_ready, pe_clear, busy, done};
      tests++;
      if (o !== '0) begin failed++; $display("FAIL abort_idle cyc=%0d got=%h exp=0", c, o); end
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = VW'($urandom); in_b = VW'($urandom);
    end
  endtask

  task automatic test_basic();
    job_a[0] = 32'h0403_0201;
    job_b[0] = 32'h0807_0605;
    job_gap[0] = 0;
    plan_job(1, 1'b0, 3);
    run_planned();
    for (int c = 0; c < n_cyc; c++) begin
      tests++;
      if (obs_o[c] !== exp_o[c]) begin failed++; $display("FAIL basic cyc=%0d got=%h exp=%h", c, obs_o[c], exp_o[c]); end
    end
    tests++;
    if (lane(obs_a[3], 0) !== 8'd1 || lane(obs_a[6], 3) !== 8'd4) begin
      failed++; $display("FAIL basic_lanes l0=%0d l3=%0d exp 1,4", lane(obs_a[3], 0), lane(obs_a[6], 3));
    end
    tests++;
    if (obs_o[10][0] !== 1'b1) begin failed++; $display("FAIL basic_done_c10 got=%b exp=1", obs_o[10][0]); end
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < NL; j++) begin
        tests++;
        if (pe_sum(i, j) !== golden(i, j, 1)) begin
          failed++; $display("FAIL basic_pe(%0d,%0d) got=%0d exp=%0d", i, j, pe_sum(i, j), golden(i, j, 1));
        end
      end
  endtask

  task automatic test_stall();
    for (int v = 0; v < 3; v++) begin
      job_a[v] = VW'($urandom);
      job_b[v] = VW'($urandom);
    end
    job_gap[0] = 0; job_gap[1] = 2; job_gap[2] = 0;
    plan_job(3, 1'b0, 2);
    run_planned();
    for (int c = 0; c < n_cyc; c++) begin
      tests++;
      if (obs_o[c] !== exp_o[c]) begin failed++; $display("FAIL stall cyc=%0d got=%h exp=%h", c, obs_o[c], exp_o[c]); end
    end
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < NL; j++) begin
        tests++;
        if (pe_sum(i, j) !== golden(i, j, 3)) begin
          failed++; $display("FAIL stall_pe(%0d,%0d) got=%0d exp=%0d", i, j, pe_sum(i, j), golden(i, j, 3));
        end
      end
  endtask

  task automatic test_zero_len();
    plan_job(0, 1'b0, 3);
    run_planned();
    for (int c = 0; c < n_cyc; c++) begin
      tests++;
      if (obs_o[c] !== exp_o[c]) begin failed++; $display("FAIL zero_len cyc=%0d got=%h exp=%h", c, obs_o[c], exp_o[c]); end
    end
  endtask

  task automatic test_start_ignored();
    for (int v = 0; v < 5; v++) begin
      job_a[v]   = VW'($urandom);
      job_b[v]   = VW'($urandom);
      job_gap[v] = $urandom_range(0, 2);
    end
    plan_job(5, 1'b1, 2);
    run_planned();
    for (int c = 0; c < n_cyc; c++) begin
      tests++;
      if (obs_o[c] !== exp_o[c]) begin failed++; $display("FAIL start_ign cyc=%0d got=%h exp=%h", c, obs_o[c], exp_o[c]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int jb = 0; jb < 2; jb++) begin
      int k = (jb == 0) ? 4 : 3;
      for (int v = 0; v < k; v++) begin
        job_a[v]   = VW'($urandom);
        job_b[v]   = VW'($urandom);
        job_gap[v] = $urandom_range(0, 1);
      end
      plan_job(k, 1'b0, (jb == 0) ? 0 : 2);
      run_planned();
      for (int c = 0; c < n_cyc; c++) begin
        tests++;
        if (obs_o[c] !== exp_o[c]) begin failed++; $display("FAIL b2b job=%0d cyc=%0d got=%h exp=%h", jb, c, obs_o[c], exp_o[c]); end
      end
      for (int i = 0; i < NL; i++)
        for (int j = 0; j < NL; j++) begin
          tests++;
          if (pe_sum(i, j) !== golden(i, j, k)) begin
            failed++; $display("FAIL b2b_pe job=%0d (%0d,%0d) got=%0d exp=%0d", jb, i, j, pe_sum(i, j), golden(i, j, k));
          end
        end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int k = $urandom_range(1, 10);
      for (int v = 0; v < k; v++) begin
        job_a[v]   = VW'($urandom);
        job_b[v]   = VW'($urandom);
        job_gap[v] = $urandom_range(0, 2);
      end
      plan_job(k, r[0], 2);
      run_planned();
      for (int c = 0; c < n_cyc; c++) begin
        tests++;
        if (obs_o[c] !== exp_o[c]) begin failed++; $display("FAIL rand r=%0d cyc=%0d got=%h exp=%h", r, c, obs_o[c], exp_o[c]); end
      end
      for (int i = 0; i < NL; i++)
        for (int j = 0; j < NL; j++) begin
          tests++;
          if (pe_sum(i, j) !== golden(i, j, k)) begin
            failed++; $display("FAIL rand_pe r=%0d (%0d,%0d) got=%0d exp=%0d", r, i, j, pe_sum(i, j), golden(i, j, k));
          end
        end
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Operand feeder directly upstream of the N x N systolic array of accumulating MAC processing elements.
- Accepts one A column-vector and one B row-vector per handshake and staggers them: lane i is delayed i cycles, so operands meet diagonally in the array.
- Clears the PE accumulators before each job, inserts zero bubbles on input stalls, flushes with zeros, and signals when every PE holds its final sum.

Parameters:
- DATA_W, 8, width of one operand element; equal to the PE data width.
- N, 4, array dimension and number of lanes per operand.
- K_W, 8, width of the k_len job-length field; maximum job length is 2^K_W-1 vectors.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  job start pulse; sampled only in IDLE.
- k_len  in  K_W  vectors in the job; sampled with start.
- in_valid  in  1  upstream has a vector pair on in_a/in_b.
- in_ready  out  1  feeder accepts a vector pair this cycle.
- in_a  in  N*DATA_W  A vector; lane i is bits [i*DATA_W +: DATA_W].
- in_b  in  N*DATA_W  B vector; same lane packing.
- out_a  out  N*DATA_W  skewed A lanes to array row inputs (in_a of PE(i,0)).
- out_b  out  N*DATA_W  skewed B lanes to array column inputs (in_b of PE(0,j)).
- pe_clear  out  1  drives the PE reset input to clear accumulators.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; all PE sums are final.

Behaviour:
- Reset (sync): state=IDLE; all delay registers, out_a, out_b, pe_clear, done, in_ready, busy, vec_cnt and flush_cnt = 0. Reset mid-job aborts the job immediately; there is no partial done.
- FSM states: IDLE, CLEAR, STREAM, FLUSH, DONE.
  - IDLE: start=1 latches k_len and goes to CLEAR. start is ignored in all other states.
  - CLEAR: pe_clear=1 for exactly this cycle. Next state is STREAM if k_len!=0, else DONE.
  - STREAM: in_ready=1. A handshake (in_valid&in_ready) loads the lanes and increments vec_cnt. When the k_len-th vector is accepted, next state is FLUSH, flush_cnt=0, and in_ready drops the following cycle.
  - FLUSH: in_ready=0 and zeros are fed. Lasts exactly 2N-1 cycles, then next state is DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Lane datapath: per operand, lane i is a registered chain of depth i+1. Lane 0 has a single output register; lane N-1 has N registers.
- Lane input value:
  - Handshake cycle: in_a/in_b lane data.
  - STREAM with in_valid=0: zero bubble in all lanes of both operands. The bubble is consistent because A and B are skewed in lockstep, and 0*x adds nothing to the accumulators.
  - All other states: zero.
- Latency: a vector accepted at edge E appears on lane i output after edge E+i+1.
- Completion: PE(N-1,N-1) accumulates the last product at edge EL+2N-1, where EL is the last acceptance edge. This sets the FLUSH length.
- Outputs are fully registered; there is no combinational path from inputs to out_a/out_b.
- Delay registers shift every cycle in every state; there is no stall of the chain.
- After done, out_a and out_b are all-zero.
- pe_clear is never asserted in the same cycle as non-zero out_a/out_b data.
- No arithmetic on data; elements pass unmodified at DATA_W bits. Counters are compared at full width.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package:
  - State enum encoding.
  - Function lane(vec,i) for slicing lane i.
  - Constant FLUSH_CYCLES = 2*N-1.
  - Flush counter width clog2(2N).
- One natural sub-module: skew_delay_line (parameters DEPTH, DATA_W). It is a DEPTH-stage register chain with sync reset and is instantiated 2N times via generate.

Test Plan:
- Reset mid-STREAM (N=4, k_len=8, reset after 3 accepts): next cycle state=IDLE, all outputs 0, and no done pulse follows.
- Basic job, k_len=1: a=[1,2,3,4], b=[5,6,7,8].
  - pe_clear is high 1 cycle after start.
  - out_a lane i shows i+1 after edge E+i+1: lane0=1 at E+1, lane3=4 at E+4; zeros otherwise.
  - done pulses 2N-1=7 cycles after entering FLUSH.
- Stall insertion, k_len=3, in_valid low for 2 cycles between vectors 1 and 2: those 2 cycles appear as all-zero slots in every lane, skewed by i. A 4x4 PE array model matches the golden A*B product.
- k_len=0: start leads to CLEAR (pe_clear=1), then DONE (done=1), then IDLE. in_ready never asserts.
- start pulsed during STREAM and FLUSH: ignored; vec_cnt and job length are unchanged.
- Back-to-back jobs: start asserted the cycle after done. The second job's pe_clear occurs while all lanes are zero, and the second result is independent of the first.
